// File: rtl/sv_rand_pkg.sv
// Shared types and constants for the sv_rand_pool entropy pool: delivery FSM
// states and the whitening LFSR feedback mask.
package sv_rand_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

endpackage

// File: rtl/sv_lfsr.sv
// 32-bit right-shifting Galois LFSR with step enable. A zero seed locks the
// register at zero, which the pool uses to disable whitening.
module sv_lfsr
    import sv_rand_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468,
    parameter logic [31:0] MASK = LFSR_MASK
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_reg;
    logic [31:0] state_next;

    // Each bit takes its upper neighbour, xored with the feedback bit where the mask taps.
    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_tap
            assign state_next[gi] = state_reg[gi+1] ^ (state_reg[0] & MASK[gi]);
        end
    endgenerate
    assign state_next[31] = state_reg[0] & MASK[31];

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_reg <= SEED;
        end else if (step) begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/sv_rand_pool.sv
// Entropy pool feeding the signing core's random-scalar input: whitens raw words,
// packs them MSB-first into a block and delivers it on request.
// Optional repetition-count health test enabled by defining SV_RAND_HEALTH_EN.
module sv_rand_pool
    import sv_rand_pkg::*;
#(
    parameter int          BLOCK_SIZE = 256,
    parameter int          ENT_WIDTH  = 8,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
    parameter int          REP_LIMIT  = 4,
    localparam int         NWORDS     = BLOCK_SIZE / ENT_WIDTH,
    localparam int         FILL_W     = $clog2(NWORDS) + 1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic [ENT_WIDTH-1:0]  ent_i,
    input  logic                  ent_valid_i,
    output logic                  ent_ready_o,
    input  logic                  rand_req_i,
    output logic                  rand_ready_o,
    output logic [BLOCK_SIZE-1:0] rand_o,
    output logic [FILL_W-1:0]     fill_o,
    output logic                  health_err_o
);

    state_e                state_reg;
    logic [BLOCK_SIZE-1:0] pool_reg;
    logic [BLOCK_SIZE-1:0] rand_reg;
    logic [FILL_W-1:0]     fill_reg;
    logic                  ready_reg;
    logic                  rand_ready_reg;
    logic                  health_reg;

    logic [31:0]           lfsr_state;
    logic                  lfsr_unused;
    logic                  accept;
    logic                  last_word;
    logic                  rep_fail;
    logic [ENT_WIDTH-1:0]  white_word;

    // ready_reg is only ever set while in FILL, so it also gates the accept.
    assign accept     = ent_valid_i & ready_reg;
    assign last_word  = (fill_reg == FILL_W'(NWORDS - 1));
    assign white_word = ent_i ^ lfsr_state[ENT_WIDTH-1:0];
    assign lfsr_unused = ^lfsr_state[31:ENT_WIDTH];

    sv_lfsr #(
        .SEED (LFSR_SEED),
        .MASK (LFSR_MASK)
    ) u_lfsr (
        .clk    (clk),
        .areset (areset),
        .step   (accept),
        .state  (lfsr_state)
    );

`ifdef SV_RAND_HEALTH_EN
    logic [ENT_WIDTH-1:0] last_reg;
    logic [3:0]           rep_reg;
    logic [3:0]           rep_next;

    // A zero count means no previous word, so the first word after a clear is always new.
    always_comb begin
        rep_next = 4'd1;
        if ((rep_reg != 4'd0) && (ent_i == last_reg)) begin
            rep_next = rep_reg + 4'd1;
        end
    end

    assign rep_fail = accept && (rep_next == 4'(REP_LIMIT));

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            last_reg <= '0;
            rep_reg  <= 4'd0;
        end else if (rep_fail) begin
            last_reg <= '0;
            rep_reg  <= 4'd0;
        end else if (accept) begin
            last_reg <= ent_i;
            rep_reg  <= rep_next;
        end
    end
`else
    localparam int REP_LIMIT_UNUSED = REP_LIMIT;
    assign rep_fail = 1'b0;
`endif

    // rand_o and rand_ready_o are loaded on the FULL->DELIVER edge so the pulse
    // and the fresh block are both presented during the DELIVER cycle.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_reg      <= FILL;
            pool_reg       <= '0;
            fill_reg       <= '0;
            rand_reg       <= '0;
            ready_reg      <= 1'b0;
            rand_ready_reg <= 1'b0;
            health_reg     <= 1'b0;
        end else begin
            rand_ready_reg <= 1'b0;
            health_reg     <= 1'b0;
            case (state_reg)
                FILL: begin
                    ready_reg <= 1'b1;
                    if (rep_fail) begin
                        pool_reg   <= '0;
                        fill_reg   <= '0;
                        health_reg <= 1'b1;
                    end else if (accept) begin
                        pool_reg <= {pool_reg[BLOCK_SIZE-ENT_WIDTH-1:0], white_word};
                        fill_reg <= fill_reg + FILL_W'(1);
                        if (last_word) begin
                            state_reg <= FULL;
                            ready_reg <= 1'b0;
                        end
                    end
                end
                FULL: begin
                    ready_reg <= 1'b0;
                    if (rand_req_i) begin
                        state_reg      <= DELIVER;
                        rand_reg       <= pool_reg;
                        rand_ready_reg <= 1'b1;
                    end
                end
                DELIVER: begin
                    pool_reg  <= '0;
                    fill_reg  <= '0;
                    ready_reg <= 1'b1;
                    state_reg <= FILL;
                end
                default: begin
                    state_reg <= FILL;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ent_ready_o  = ready_reg;
    assign rand_ready_o = rand_ready_reg;
    assign rand_o       = rand_reg;
    assign fill_o       = fill_reg;
    assign health_err_o = health_reg;

endmodule

// File: tb/tb_sv_rand_pool.sv
// Scoreboard bench for sv_rand_pool: one instance with whitening disabled and one
// with the default seed, driven by identical stimulus.
`timescale 1ns/1ps
module tb_sv_rand_pool;

    localparam int          BS        = 256;
    localparam int          EW        = 8;
    localparam int          NW        = 32;
    localparam int          FW        = 6;
    localparam int          REP_LIMIT = 4;
    localparam logic [31:0] SEED      = 32'hACE1_2468;
    localparam logic [31:0] MASK      = 32'h8020_0003;
`ifdef SV_RAND_HEALTH_EN
    localparam bit          HEALTH    = 1'b1;
`else
    localparam bit          HEALTH    = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic [EW-1:0] ent_i = '0;
    logic          ent_valid_i = 1'b0;
    logic          rand_req_i = 1'b0;

    logic          rdy_p, rr_p, herr_p;
    logic [BS-1:0] rand_p;
    logic [FW-1:0] fill_p;
    logic          rdy_w, rr_w, herr_w;
    logic [BS-1:0] rand_w;
    logic [FW-1:0] fill_w;

    sv_rand_pool #(.BLOCK_SIZE(BS), .ENT_WIDTH(EW), .LFSR_SEED(32'h0), .REP_LIMIT(REP_LIMIT)) u_plain (
        .clk(clk), .areset(areset), .ent_i(ent_i), .ent_valid_i(ent_valid_i),
        .ent_ready_o(rdy_p), .rand_req_i(rand_req_i), .rand_ready_o(rr_p),
        .rand_o(rand_p), .fill_o(fill_p), .health_err_o(herr_p)
    );

    sv_rand_pool #(.BLOCK_SIZE(BS), .ENT_WIDTH(EW), .LFSR_SEED(SEED), .REP_LIMIT(REP_LIMIT)) u_white (
        .clk(clk), .areset(areset), .ent_i(ent_i), .ent_valid_i(ent_valid_i),
        .ent_ready_o(rdy_w), .rand_req_i(rand_req_i), .rand_ready_o(rr_w),
        .rand_o(rand_w), .fill_o(fill_w), .health_err_o(herr_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [BS-1:0] q_p[$];
    logic [BS-1:0] q_w[$];
    int            ready_cycles[$];
    int            health_expected = 0;
    int            health_seen_p = 0;
    int            health_seen_w = 0;

    // Reference model
    logic [BS-1:0] pool_p, pool_w;
    logic [31:0]   mdl_lfsr;
    int            mdl_fill;
    int            blocks = 0;
`ifdef SV_RAND_HEALTH_EN
    logic [EW-1:0] mdl_last;
    int            mdl_rep;
`endif

    task automatic check(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic logic [31:0] galois(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
    endfunction

    task automatic model_reset();
        pool_p   = '0;
        pool_w   = '0;
        mdl_fill = 0;
        mdl_lfsr = SEED;
`ifdef SV_RAND_HEALTH_EN
        mdl_last = '0;
        mdl_rep  = 0;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the edge that accepted d.
    task automatic model_accept(input logic [EW-1:0] d);
        logic [EW-1:0] w;
        bit            drop;
        w    = mdl_lfsr[EW-1:0];
        drop = 1'b0;
`ifdef SV_RAND_HEALTH_EN
        if (mdl_rep != 0 && d == mdl_last) mdl_rep++;
        else mdl_rep = 1;
        mdl_last = d;
        if (mdl_rep == REP_LIMIT) begin
            drop = 1'b1;
            mdl_rep = 0;
            mdl_last = '0;
            health_expected++;
        end
`endif
        mdl_lfsr = galois(mdl_lfsr);
        check("health_pulse_plain", herr_p, drop);
        check("health_pulse_white", herr_w, drop);
        if (drop) begin
            pool_p = '0;
            pool_w = '0;
            mdl_fill = 0;
        end else begin
            pool_p = {pool_p[BS-EW-1:0], d};
            pool_w = {pool_w[BS-EW-1:0], d ^ w};
            mdl_fill++;
        end
        if (mdl_fill == NW) begin
            check("fill_full", fill_p, NW);
            check("ready_drop", rdy_p, 0);
            q_p.push_back(pool_p);
            q_w.push_back(pool_w);
            pool_p = '0;
            pool_w = '0;
            mdl_fill = 0;
            blocks++;
        end else begin
            check("fill_plain", fill_p, mdl_fill);
            check("fill_white", fill_w, mdl_fill);
        end
    endtask

    task automatic send_word(input logic [EW-1:0] d);
        int waited;
        ent_i = d;
        ent_valid_i = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!rdy_p) begin
            waited++;
            if (waited > 100) begin
                note_fail("accept");
                return;
            end
            @(negedge clk);
        end
        step();
        model_accept(d);
    endtask

    task automatic fill_until_block(input logic [EW-1:0] base);
        int start;
        int i;
        start = blocks;
        i = 0;
        while (blocks == start && i < 64) begin
            send_word(base + EW'(i));
            i++;
        end
        if (blocks == start) note_fail("fill_block");
    endtask

    // Entered in the FULL cycle with rand_req_i already high; leaves us in the DELIVER cycle.
    task automatic deliver_pulse();
        check("ready_in_full", rr_p, 0);
        step();
        check("ready_pulse_plain", rr_p, 1);
        check("ready_pulse_white", rr_w, 1);
    endtask

    task automatic deliver_done();
        step();
        check("fill_after_deliver", fill_p, 0);
        check("ready_single_cycle", rr_p, 0);
    endtask

    // Monitor: pops the scoreboard whenever a block is presented.
    always @(negedge clk) begin
        if (rr_p) begin
            ready_cycles.push_back(cyc);
            if (q_p.size() == 0) note_fail("plain_unexpected_block");
            else check("plain_block", rand_p, q_p.pop_front());
        end
        if (rr_w) begin
            if (q_w.size() == 0) note_fail("white_unexpected_block");
            else check("white_block", rand_w, q_w.pop_front());
        end
        if (herr_p) health_seen_p <= health_seen_p + 1;
        if (herr_w) health_seen_w <= health_seen_w + 1;
        if (rr_p || herr_p) check("ready_health_exclusive", rr_p & herr_p, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rand_ready", rr_p, 0);
        check("reset_rand_o", rand_p, 0);
        check("reset_fill", fill_p, 0);
        check("reset_ent_ready", rdy_p, 0);
        check("reset_health", herr_p, 0);
        check("reset_rand_o_white", rand_w, 0);
        @(negedge clk);
        areset = 1'b1;
        step();
        check("ready_after_reset", rdy_p, 1);

        // Whitening from the seed: zero input exposes the LFSR low bytes.
        rand_req_i = 1'b1;
        for (int i = 0; i < NW; i++) send_word(HEALTH ? EW'(i) : 8'h00);
        ent_valid_i = 1'b0;
        deliver_pulse();
        check("white_first_byte", rand_w[BS-1:BS-8], 8'h68);
        deliver_done();

        // Bytes 0x01..0x20 with the request held from the start.
        for (int i = 1; i <= NW; i++) send_word(EW'(i));
        ent_valid_i = 1'b0;
        deliver_pulse();
        check("plain_msb_byte", rand_p[BS-1:BS-8], 8'h01);
        check("plain_lsb_byte", rand_p[7:0], 8'h20);
        deliver_done();

        // FULL with no request: input back-pressured, no delivery.
        rand_req_i = 1'b0;
        for (int i = 0; i < NW; i++) send_word(8'h40 + EW'(i));
        ent_i = 8'h99;
        for (int i = 0; i < 10; i++) begin
            step();
            check("full_hold_fill", fill_p, NW);
            check("full_no_ready", rr_p, 0);
        end
        rand_req_i = 1'b1;
        ent_valid_i = 1'b0;
        deliver_pulse();
        deliver_done();

        // Repetition run: 0x11, 0x22 then 0xAA four times.
        send_word(8'h11);
        send_word(8'h22);
        for (int i = 0; i < 4; i++) send_word(8'hAA);
        check("fill_after_repeats", fill_p, HEALTH ? 0 : 6);
        fill_until_block(8'h30);
        ent_valid_i = 1'b0;
        deliver_pulse();
        deliver_done();

        // Reset in the middle of a fill with the request pending.
        for (int i = 0; i < 17; i++) send_word(8'h60 + EW'(i));
        ent_valid_i = 1'b0;
        #2;
        areset = 1'b0;
        #1;
        check("midreset_fill", fill_p, 0);
        check("midreset_rand_o", rand_p, 0);
        check("midreset_rand_o_white", rand_w, 0);
        check("midreset_rand_ready", rr_p, 0);
        check("midreset_ent_ready", rdy_p, 0);
        check("midreset_health", herr_p, 0);
        model_reset();
        step();
        step();
        @(negedge clk);
        areset = 1'b1;
        step();
        for (int i = 0; i < NW - 1; i++) send_word(8'h80 + EW'(i));
        ent_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("postreset_no_ready", rr_p, 0);
            check("postreset_fill", fill_p, NW - 1);
        end
        fill_until_block(8'hC0);
        ent_valid_i = 1'b0;
        deliver_pulse();
        deliver_done();

        // Back-to-back streaming with the request held.
        ready_cycles.delete();
        for (int b = 0; b < 3; b++) fill_until_block(EW'(b * 40));
        ent_valid_i = 1'b0;
        deliver_pulse();
        deliver_done();
        check("b2b_pulse_count", ready_cycles.size(), 3);
        if (ready_cycles.size() == 3) begin
            check("b2b_gap_1", ready_cycles[1] - ready_cycles[0], 34);
            check("b2b_gap_2", ready_cycles[2] - ready_cycles[1], 34);
        end

        repeat (2) step();
        check("plain_queue_empty", q_p.size(), 0);
        check("white_queue_empty", q_w.size(), 0);
        check("health_count_plain", health_seen_p, health_expected);
        check("health_count_white", health_seen_w, health_expected);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
